// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush/forward sequencing for the five-stage pipeline
module hazard_control_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              mispredict_E,
  input  logic [XLEN-1:0]   CorrectPCE,
  input  logic              imem_ready,
  input  logic              dmem_req_M,
  input  logic              dmem_ready_M,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [1:0]        PCNextSelF,
  output logic [XLEN-1:0]   RedirectPCF,
  output logic [XLEN-1:0]   stall_cycles,
  output logic [XLEN-1:0]   flush_count
);
  typedef enum logic {RUN, DWAIT} state_t;
  state_t state_q, state_d;
  logic redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d, stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  logic frozen, mp, redir_go, lu, stall_d, stall_f, flush_d, flush_e;
  logic [1:0] pc_sel, fwd_a, fwd_b;
  always_comb begin
    frozen   = (state_q == DWAIT) ? ~dmem_ready_M : (dmem_req_M & ~dmem_ready_M);
    mp       = mispredict_E & ~frozen;
    redir_go = redir_pend_q & imem_ready & ~mp;
    lu       = ResultSrcE0 && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    // a redirect in flight makes the decode contents wrong-path, so load-use must not hold fetch
    stall_d  = frozen | (lu & ~mp & ~redir_go);
    stall_f  = stall_d | ~imem_ready;
    flush_d  = ~frozen & (mp | (~stall_d & (~imem_ready | redir_go)));
    flush_e  = ~frozen & (mp | stall_d);
    pc_sel   = frozen ? 2'b00 : mp ? (imem_ready ? 2'b01 : 2'b00) : redir_go ? 2'b10 : 2'b00;
    fwd_a    = (RegWriteM && RdM != '0 && RdM == Rs1E) ? 2'b10 :
               (RegWriteW && RdW != '0 && RdW == Rs1E) ? 2'b01 : 2'b00;
    fwd_b    = (RegWriteM && RdM != '0 && RdM == Rs2E) ? 2'b10 :
               (RegWriteW && RdW != '0 && RdW == Rs2E) ? 2'b01 : 2'b00;
    state_d        = frozen ? DWAIT : RUN;
    redir_pend_d   = frozen ? redir_pend_q : mp ? ~imem_ready : imem_ready ? 1'b0 : redir_pend_q;
    redir_pc_d     = (mp & ~imem_ready) ? CorrectPCE : redir_pc_q;
    stall_cycles_d = stall_cycles_q + XLEN'(stall_f);
    flush_count_d  = flush_count_q + XLEN'(mp);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      redir_pend_q   <= 1'b0;
      redir_pc_q     <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      redir_pend_q   <= redir_pend_d;
      redir_pc_q     <= redir_pc_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end
  assign StallF       = ~rst & stall_f;
  assign StallD       = ~rst & stall_d;
  assign StallE       = ~rst & frozen;
  assign StallM       = ~rst & frozen;
  assign StallW       = ~rst & frozen;
  assign FlushD       = ~rst & flush_d;
  assign FlushE       = ~rst & flush_e;
  assign ForwardAE    = rst ? 2'b00 : fwd_a;
  assign ForwardBE    = rst ? 2'b00 : fwd_b;
  assign PCNextSelF   = rst ? 2'b00 : pc_sel;
  assign RedirectPCF  = redir_pc_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_hazard_control_unit;
  logic clk = 0, rst = 1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, ResultSrcE0, mispredict_E, imem_ready, dmem_req_M, dmem_ready_M;
  logic [31:0] CorrectPCE, RedirectPCF, stall_cycles, flush_count;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE, PCNextSelF;
  typedef struct {
    string       nm;
    logic [12:0] ctl;
    logic [31:0] rpc, sc, fc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  hazard_control_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .mispredict_E(mispredict_E), .CorrectPCE(CorrectPCE), .imem_ready(imem_ready),
    .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCNextSelF(PCNextSelF),
    .RedirectPCF(RedirectPCF), .stall_cycles(stall_cycles), .flush_count(flush_count));
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if ({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, PCNextSelF,
           RedirectPCF, stall_cycles, flush_count} !== {e.ctl, e.rpc, e.sc, e.fc}) begin
        fails++;
        $display("FAIL %s: got ctl=%b rpc=%h sc=%0d fc=%0d, expected ctl=%b rpc=%h sc=%0d fc=%0d", e.nm,
                 {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, PCNextSelF},
                 RedirectPCF, stall_cycles, flush_count, e.ctl, e.rpc, e.sc, e.fc);
      end
    end
  end
  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, mispredict_E, dmem_req_M, dmem_ready_M} = '0;
    CorrectPCE = '0;
    imem_ready = 1'b1;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic push(input string nm, input logic [12:0] ctl, input logic [31:0] rpc, sc, fc);
    sb.push_back('{nm, ctl, rpc, sc, fc});
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    imem_ready = 0; mispredict_E = 1; dmem_req_M = 1; ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    push("reset", 13'b00000_00_00_00_00, 0, 0, 0);
    next(); rst = 0;
    RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 5; Rs1E = 5;
    push("fwd_m", 13'b00000_00_10_00_00, 0, 0, 0);
    next();
    RegWriteM = 1; RegWriteW = 1; RdM = 0; RdW = 5; Rs1E = 5; Rs2E = 5;
    push("fwd_w", 13'b00000_00_01_01_00, 0, 0, 0);
    next();
    RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 5; Rs2E = 7;
    push("fwd_b_m", 13'b00000_00_00_10_00, 0, 0, 0);
    next();
    RegWriteM = 1; RegWriteW = 1;
    push("fwd_x0", 13'b00000_00_00_00_00, 0, 0, 0);
    next();
    ResultSrcE0 = 1; RdE = 3; Rs2D = 3;
    push("load_use", 13'b11000_01_00_00_00, 0, 0, 0);
    next();
    push("load_use_after", 13'b00000_00_00_00_00, 0, 1, 0);
    next();
    ResultSrcE0 = 1;
    push("load_use_x0", 13'b00000_00_00_00_00, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      next();
      dmem_req_M = 1; mispredict_E = 1; CorrectPCE = 32'h200;
      push("freeze", 13'b11111_00_00_00_00, 0, 1 + i, 0);
    end
    next();
    dmem_req_M = 1; dmem_ready_M = 1; mispredict_E = 1; CorrectPCE = 32'h200;
    push("freeze_ready", 13'b00000_11_00_00_01, 0, 4, 0);
    next();
    push("freeze_after", 13'b00000_00_00_00_00, 0, 4, 1);
    next();
    imem_ready = 0; mispredict_E = 1; CorrectPCE = 32'h100;
    push("pend_set", 13'b10000_11_00_00_00, 0, 4, 1);
    for (int i = 0; i < 2; i++) begin
      next();
      imem_ready = 0;
      push("pend_wait", 13'b10000_10_00_00_00, 32'h100, 5 + i, 2);
    end
    next();
    push("pend_redirect", 13'b00000_10_00_00_10, 32'h100, 7, 2);
    next();
    push("pend_cleared", 13'b00000_00_00_00_00, 32'h100, 7, 2);
    next();
    imem_ready = 0; mispredict_E = 1; CorrectPCE = 32'h300;
    push("pend_set2", 13'b10000_11_00_00_00, 32'h100, 7, 2);
    next();
    imem_ready = 0; mispredict_E = 1; CorrectPCE = 32'h400;
    push("pend_overwrite", 13'b10000_11_00_00_00, 32'h300, 8, 3);
    next();
    push("pend_redirect2", 13'b00000_10_00_00_10, 32'h400, 9, 4);
    next();
    imem_ready = 0; mispredict_E = 1; CorrectPCE = 32'h500;
    push("pend_set3", 13'b10000_11_00_00_00, 32'h400, 9, 4);
    next();
    mispredict_E = 1; CorrectPCE = 32'h600;
    push("pend_mp_prio", 13'b00000_11_00_00_01, 32'h500, 10, 5);
    next();
    push("pend_mp_after", 13'b00000_00_00_00_00, 32'h500, 10, 6);
    next();
    imem_ready = 0; mispredict_E = 1; CorrectPCE = 32'h700;
    push("pend_set4", 13'b10000_11_00_00_00, 32'h500, 10, 6);
    for (int i = 0; i < 2; i++) begin
      next();
      imem_ready = 0; dmem_req_M = 1;
      push("pend_freeze", 13'b11111_00_00_00_00, 32'h700, 11 + i, 7);
    end
    next();
    imem_ready = 0; dmem_req_M = 1; rst = 1;
    push("mid_reset", 13'b00000_00_00_00_00, 0, 0, 0);
    next(); rst = 0;
    push("post_reset", 13'b00000_00_00_00_00, 0, 0, 0);
    next();
    ResultSrcE0 = 1; RdE = 3; Rs1D = 3; mispredict_E = 1; CorrectPCE = 32'h800;
    push("mp_over_lu", 13'b00000_11_00_00_01, 0, 0, 0);
    next();
    push("mp_over_lu_after", 13'b00000_00_00_00_00, 0, 0, 1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d unchecked, expected 0", sb.size());
      fails += sb.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
